// File: rtl/fc_seq_ctrl_if.sv
// Bus bundle between the FC sequencer and its surroundings: command inputs
// from the APB block, the input weight/feature stream, the feature-buffer and
// MAC control strobes, the result stream and the status outputs.
//
// Handshake rule for both streams: a beat transfers on a rising clk edge where
// valid and ready are both high. A source holds valid and its payload steady
// until that edge. The sequencer's ready never depends on its own valid
// outputs.
interface fc_seq_ctrl_if #(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 16
);
  // command / configuration
  logic              start;
  logic [CNT_W-1:0]  in_words;
  logic [CNT_W-1:0]  out_len;

  // input stream
  logic              s_valid;
  logic              s_last;
  logic              s_ready;

  // feature buffer and MAC control
  logic              feat_we;
  logic [ADDR_W-1:0] feat_addr;
  logic              mac_en;
  logic [ADDR_W-1:0] mac_addr;
  logic              acc_clr;
  logic [31:0]       acc_in;

  // result stream
  logic              m_valid;
  logic              m_ready;
  logic [31:0]       m_data;
  logic              m_last;

  // status
  logic [CNT_W-1:0]  max_index;
  logic              busy;
  logic              done;
  logic              err;

  // sequencer side
  modport master (
    input  start, in_words, out_len, s_valid, s_last, acc_in, m_ready,
    output s_ready, feat_we, feat_addr, mac_en, mac_addr, acc_clr,
           m_valid, m_data, m_last, max_index, busy, done, err
  );

  // environment side (APB block, stream source/sink, datapath)
  modport slave (
    output start, in_words, out_len, s_valid, s_last, acc_in, m_ready,
    input  s_ready, feat_we, feat_addr, mac_en, mac_addr, acc_clr,
           m_valid, m_data, m_last, max_index, busy, done, err
  );
endinterface

// File: rtl/fc_seq_ctrl.sv
// Control sequencer for one fully-connected layer per start command.
// LOAD streams the feature vector into the feature buffer, then each ROW
// streams one weight row through the MAC, DRAIN waits out the MAC pipeline,
// EMIT presents the accumulator result and tracks the arg-max, DONE pulses.
// The FSM state is exported on o_state for observation.
module fc_seq_ctrl #(
  parameter int ADDR_W  = 10,
  parameter int CNT_W   = 16,
  parameter int MAC_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  fc_seq_ctrl_if.master bus,
  output logic [2:0]    o_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ROW   = 3'd2,
    S_DRAIN = 3'd3,
    S_EMIT  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] LP_ONE     = CNT_W'(1);
  localparam logic [3:0]       LP_LAT     = 4'(MAC_LAT);
  localparam logic [3:0]       LP_LAT_ONE = 4'd1;

  state_t                   r_state;
  state_t                   w_next;

  logic [CNT_W-1:0]         r_in_words;
  logic [CNT_W-1:0]         r_out_len;
  logic [CNT_W-1:0]         r_word_cnt;
  logic [CNT_W-1:0]         r_row_cnt;
  logic [CNT_W-1:0]         r_max_index;
  logic [3:0]               r_lat_cnt;
  logic [31:0]              r_m_data;
  logic signed [31:0]       r_max_val;
  logic                     r_err;

  logic                     w_s_hs;
  logic                     w_m_hs;
  logic                     w_last_word;
  logic                     w_last_row;
  logic                     w_bad_last;
  logic                     w_zero_len;
  logic                     w_lat_end;
  logic                     w_new_max;

  logic                     w_s_ready;
  logic                     w_feat_we;
  logic                     w_mac_en;
  logic                     w_acc_clr;
  logic                     w_m_valid;
  logic                     w_done;

  // A stream beat can only transfer while the FSM is consuming the stream.
  assign w_s_hs      = bus.s_valid && ((r_state == S_LOAD) || (r_state == S_ROW));
  assign w_m_hs      = (r_state == S_EMIT) && bus.m_ready;
  assign w_last_word = (r_word_cnt == (r_in_words - LP_ONE));
  assign w_last_row  = (r_row_cnt == (r_out_len - LP_ONE));
  // TLAST is only legal on the very last beat of the very last row.
  assign w_bad_last  = bus.s_last && !(w_last_word && w_last_row);
  // Uses the live command inputs so an empty layer reaches DONE one cycle after start.
  assign w_zero_len  = (bus.in_words == '0) || (bus.out_len == '0);
  // The latency counter is loaded with MAC_LAT after the last mac_en; acc_in
  // is valid in the DRAIN cycle where the count is about to reach zero.
  assign w_lat_end   = (r_lat_cnt == LP_LAT_ONE);
  // Row 0 always seeds the arg-max; later rows need a strictly larger value,
  // so ties keep the lower index.
  assign w_new_max   = (r_row_cnt == '0) || ($signed(bus.acc_in) > r_max_val);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode and per-state control strobes.
  always_comb begin
    w_next    = r_state;
    w_s_ready = 1'b0;
    w_feat_we = 1'b0;
    w_mac_en  = 1'b0;
    w_acc_clr = 1'b0;
    w_m_valid = 1'b0;
    w_done    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_next = w_zero_len ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        w_s_ready = 1'b1;
        w_feat_we = bus.s_valid;
        if (w_s_hs && w_last_word) begin
          w_next = S_ROW;
        end
      end
      S_ROW: begin
        w_s_ready = 1'b1;
        w_mac_en  = bus.s_valid;
        w_acc_clr = bus.s_valid && (r_word_cnt == '0);
        if (w_s_hs) begin
          if (w_bad_last) begin
            w_next = S_DONE;
          end else if (w_last_word) begin
            w_next = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (w_lat_end) begin
          w_next = S_EMIT;
        end
      end
      S_EMIT: begin
        w_m_valid = 1'b1;
        if (w_m_hs) begin
          w_next = w_last_row ? S_DONE : S_ROW;
        end
      end
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Layer configuration, counters, result register, arg-max and error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_words  <= '0;
      r_out_len   <= '0;
      r_word_cnt  <= '0;
      r_row_cnt   <= '0;
      r_max_index <= '0;
      r_max_val   <= '0;
      r_lat_cnt   <= '0;
      r_m_data    <= '0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_in_words  <= bus.in_words;
            r_out_len   <= bus.out_len;
            r_word_cnt  <= '0;
            r_row_cnt   <= '0;
            r_max_index <= '0;
            r_max_val   <= '0;
            r_lat_cnt   <= '0;
            r_err       <= w_zero_len;
          end
        end
        S_LOAD: begin
          if (w_s_hs) begin
            r_word_cnt <= w_last_word ? '0 : (r_word_cnt + LP_ONE);
          end
        end
        S_ROW: begin
          if (w_s_hs) begin
            if (w_bad_last) begin
              r_err <= 1'b1;
            end else if (w_last_word) begin
              r_word_cnt <= '0;
              r_lat_cnt  <= LP_LAT;
            end else begin
              r_word_cnt <= r_word_cnt + LP_ONE;
            end
          end
        end
        S_DRAIN: begin
          r_lat_cnt <= r_lat_cnt - LP_LAT_ONE;
          if (w_lat_end) begin
            r_m_data <= bus.acc_in;
            if (w_new_max) begin
              r_max_val   <= $signed(bus.acc_in);
              r_max_index <= r_row_cnt;
            end
          end
        end
        S_EMIT: begin
          if (w_m_hs && !w_last_row) begin
            r_row_cnt  <= r_row_cnt + LP_ONE;
            r_word_cnt <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Addresses are driven only alongside their strobe; they truncate to ADDR_W.
  assign bus.s_ready   = w_s_ready;
  assign bus.feat_we   = w_feat_we;
  assign bus.feat_addr = w_feat_we ? r_word_cnt[ADDR_W-1:0] : '0;
  assign bus.mac_en    = w_mac_en;
  assign bus.mac_addr  = w_mac_en ? r_word_cnt[ADDR_W-1:0] : '0;
  assign bus.acc_clr   = w_acc_clr;
  assign bus.m_valid   = w_m_valid;
  assign bus.m_data    = r_m_data;
  assign bus.m_last    = w_m_valid && w_last_row;
  assign bus.max_index = r_max_index;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = w_done;
  assign bus.err       = r_err;
  assign o_state       = r_state;

endmodule

// File: tb/tb_fc_seq_ctrl.sv
// Directed bench for fc_seq_ctrl: drives layers through the stream ports,
// models the MAC datapath latency, and checks results against a scoreboard.
module tb_fc_seq_ctrl;

  localparam int ADDR_W  = 10;
  localparam int CNT_W   = 16;
  localparam int MAC_LAT = 2;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] state;

  int n_pass  = 0;
  int n_total = 0;

  logic [32:0]        exp_q[$];
  logic [ADDR_W-1:0]  feat_log[$];
  logic [ADDR_W:0]    mac_log[$];
  int                 done_cnt   = 0;
  int                 mvalid_cnt = 0;
  int                 sready_cnt = 0;

  logic signed [31:0] res_tab [0:7];
  int                 cur_words = 1;

  int                 dp_beat;
  logic               dv [MAC_LAT];
  logic [31:0]        dd [MAC_LAT];

  fc_seq_ctrl_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  fc_seq_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .MAC_LAT(MAC_LAT)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .o_state (state)
  );

  // clock
  always #5 clk = ~clk;

  // Datapath model: the result of a row appears on acc_in exactly MAC_LAT
  // cycles after the row's last mac_en, and is garbage otherwise.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_beat <= 0;
      for (int i = 0; i < MAC_LAT; i++) begin
        dv[i] <= 1'b0;
        dd[i] <= '0;
      end
    end else begin
      if (bus.done) dp_beat <= 0;
      else if (bus.mac_en) dp_beat <= dp_beat + 1;
      dv[0] <= bus.mac_en && ((dp_beat % cur_words) == (cur_words - 1));
      dd[0] <= res_tab[(dp_beat / cur_words) & 7];
      for (int i = 1; i < MAC_LAT; i++) begin
        dv[i] <= dv[i-1];
        dd[i] <= dd[i-1];
      end
    end
  end
  assign bus.acc_in = dv[MAC_LAT-1] ? dd[MAC_LAT-1] : 32'h5A5A_5A5A;

  // Monitor: logs strobes for later inspection by the directed sequence.
  always @(negedge clk) begin
    if (bus.feat_we) feat_log.push_back(bus.feat_addr);
    if (bus.mac_en)  mac_log.push_back({bus.acc_clr, bus.mac_addr});
    if (bus.done)    done_cnt++;
    if (bus.m_valid) mvalid_cnt++;
    if (bus.s_ready) sready_cnt++;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
  endtask

  function automatic logic [127:0] outs_vec();
    return 128'({bus.s_ready, bus.feat_we, bus.feat_addr, bus.mac_en, bus.mac_addr,
                 bus.acc_clr, bus.m_valid, bus.m_data, bus.m_last, bus.max_index,
                 bus.busy, bus.done, bus.err, state});
  endfunction

  // driver: one start pulse with the given configuration
  task automatic start_layer(input int nw, input int nr);
    @(posedge clk); #1;
    cur_words    = (nw == 0) ? 1 : nw;
    bus.in_words = CNT_W'(nw);
    bus.out_len  = CNT_W'(nr);
    bus.start    = 1'b1;
    @(posedge clk); #1;
    bus.start    = 1'b0;
  endtask

  // driver: one input-stream beat; s_valid is left high for back-to-back beats
  task automatic send_beat(input logic last);
    int t;
    t = 0;
    if ($urandom_range(0, 3) == 0) begin
      bus.s_valid = 1'b0;
      @(posedge clk); #1;
    end
    bus.s_valid = 1'b1;
    bus.s_last  = last;
    @(negedge clk);
    while (!bus.s_ready && t < 50) begin
      t++;
      @(negedge clk);
    end
    check("s_ready_for_beat", 128'(bus.s_ready), 128'(1));
    @(posedge clk); #1;
  endtask

  task automatic load_features(input int nw, input bit mid_start);
    for (int w = 0; w < nw; w++) begin
      send_beat(1'($urandom_range(0, 1)));
      if (mid_start && w == 1) begin
        bus.s_valid  = 1'b0;
        bus.s_last   = 1'b0;
        bus.in_words = CNT_W'(9);
        bus.out_len  = CNT_W'(9);
        bus.start    = 1'b1;
        @(posedge clk); #1;
        bus.start    = 1'b0;
        bus.in_words = CNT_W'(nw);
        @(negedge clk);
        check("ignored_start_state", 128'(state), 128'(ST_LOAD));
        check("ignored_start_busy", 128'(bus.busy), 128'(1));
        @(posedge clk); #1;
      end
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic send_row(input int r, input int nr, input int nw);
    for (int w = 0; w < nw; w++) send_beat((r == nr - 1) && (w == nw - 1));
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  // sink: waits for a result, optionally stalls, then pops the scoreboard
  task automatic take_result(input int bp);
    int          t;
    logic [31:0] held;
    logic [32:0] e;
    t = 0;
    @(negedge clk);
    while (!bus.m_valid && t < 50) begin
      t++;
      @(negedge clk);
    end
    check("m_valid_seen", 128'(bus.m_valid), 128'(1));
    check("s_ready_low_in_emit", 128'(bus.s_ready), 128'(0));
    held = bus.m_data;
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      check("m_data_stable", 128'(bus.m_data), 128'(held));
      check("m_valid_held", 128'(bus.m_valid), 128'(1));
      check("s_ready_low_stall", 128'(bus.s_ready), 128'(0));
    end
    bus.m_ready = 1'b1;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = '1;
    check("result_last_data", 128'({bus.m_last, bus.m_data}), 128'(e));
    @(posedge clk); #1;
    bus.m_ready = 1'b0;
  endtask

  task automatic wait_done(input logic exp_err, input int exp_max, input int limit);
    int t;
    t = 0;
    @(negedge clk);
    while (!bus.done && t < limit) begin
      t++;
      @(negedge clk);
    end
    check("done_seen", 128'(bus.done), 128'(1));
    check("err_at_done", 128'(bus.err), 128'(exp_err));
    check("max_index", 128'(bus.max_index), 128'(exp_max));
    @(negedge clk);
    check("done_one_cycle", 128'(bus.done), 128'(0));
    check("idle_after_done", 128'(state), 128'(ST_IDLE));
    check("busy_low_idle", 128'(bus.busy), 128'(0));
    check("err_hold", 128'(bus.err), 128'(exp_err));
    check("max_index_hold", 128'(bus.max_index), 128'(exp_max));
  endtask

  task automatic run_layer(input int nw, input int nr, input int bp, input bit mid_start);
    int f0, m0, d0, mi;
    logic [ADDR_W:0] e;
    f0 = feat_log.size();
    m0 = mac_log.size();
    d0 = done_cnt;
    mi = 0;
    exp_q.delete();
    for (int r = 0; r < nr; r++) begin
      exp_q.push_back({(r == nr - 1), res_tab[r]});
      if (r > 0 && res_tab[r] > res_tab[mi]) mi = r;
    end
    start_layer(nw, nr);
    @(negedge clk);
    check("err_cleared_on_start", 128'(bus.err), 128'(0));
    check("load_after_start", 128'(state), 128'(ST_LOAD));
    @(posedge clk); #1;
    load_features(nw, mid_start);
    for (int r = 0; r < nr; r++) begin
      send_row(r, nr, nw);
      take_result(bp);
    end
    wait_done(1'b0, mi, 20);
    check("feat_we_count", 128'(feat_log.size() - f0), 128'(nw));
    for (int i = 0; i < nw; i++) check("feat_addr", 128'(feat_log[f0 + i]), 128'(i));
    check("mac_en_count", 128'(mac_log.size() - m0), 128'(nw * nr));
    for (int k = 0; k < nw * nr; k++) begin
      e = {((k % nw) == 0), ADDR_W'(k % nw)};
      check("acc_clr_mac_addr", 128'(mac_log[m0 + k]), 128'(e));
    end
    check("single_done", 128'(done_cnt - d0), 128'(1));
    check("scoreboard_empty", 128'(exp_q.size()), 128'(0));
  endtask

  // directed sequence
  initial begin
    int d0, s0, v0;
    bus.start    = 1'b0;
    bus.in_words = '0;
    bus.out_len  = '0;
    bus.s_valid  = 1'b0;
    bus.s_last   = 1'b0;
    bus.m_ready  = 1'b0;
    for (int i = 0; i < 8; i++) res_tab[i] = '0;

    // reset
    #2 rst = 1'b1;
    #1 check("reset_outputs", outs_vec(), 128'(0));
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("idle_after_reset", outs_vec(), 128'(0));

    // basic layer
    res_tab[0] = 10; res_tab[1] = -5; res_tab[2] = 7;
    run_layer(4, 3, 0, 1'b0);

    // back-pressure, with an ignored start mid-LOAD
    v0 = mvalid_cnt;
    run_layer(4, 3, 5, 1'b1);
    check("m_valid_cycles_bp", 128'(mvalid_cnt - v0), 128'(3 * 6));

    // early TLAST on beat 2 of row 0
    res_tab[0] = 100; res_tab[1] = 200;
    v0 = mvalid_cnt;
    start_layer(4, 2);
    load_features(4, 1'b0);
    send_beat(1'b0);
    send_beat(1'b1);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    wait_done(1'b1, 0, 20);
    check("no_m_valid_on_abort", 128'(mvalid_cnt - v0), 128'(0));

    // arg-max ties and negatives; start also clears the abort error
    res_tab[0] = -8; res_tab[1] = -3; res_tab[2] = -3; res_tab[3] = -9;
    run_layer(3, 4, 0, 1'b0);

    // zero out_len, then zero in_words
    s0 = sready_cnt;
    start_layer(4, 0);
    wait_done(1'b1, 0, 2);
    start_layer(0, 3);
    wait_done(1'b1, 0, 2);
    check("no_s_ready_zero_len", 128'(sready_cnt - s0), 128'(0));

    // reset during row 1
    res_tab[0] = 3; res_tab[1] = 40; res_tab[2] = -1;
    exp_q.delete();
    exp_q.push_back({1'b0, res_tab[0]});
    start_layer(3, 3);
    load_features(3, 1'b0);
    send_row(0, 3, 3);
    take_result(0);
    send_beat(1'b0);
    check("mac_en_before_rst", 128'(bus.mac_en), 128'(1));
    d0  = done_cnt;
    rst = 1'b1;
    #1 check("outputs_zero_in_rst", outs_vec(), 128'(0));
    bus.s_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("no_done_on_rst", 128'(done_cnt - d0), 128'(0));
    check("idle_after_rst", 128'(state), 128'(ST_IDLE));

    // full layer after reset
    res_tab[0] = 5; res_tab[1] = 12; res_tab[2] = 12;
    run_layer(3, 3, 1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_total + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fc_seq_ctrl.md
Name: fc_seq_ctrl

Overview:
- Control sequencer for the fully-connected datapath. It runs one FC layer per start command.
- Phase 1 loads the input feature vector from the input stream into the feature buffer.
- Phase 2 consumes one weight row per output neuron, driving the MAC/accumulator. After each row it emits the accumulator result on the output stream.
- It tracks the arg-max output index, then reports done to the APB register bank and the cycle counter.

Parameters:
- ADDR_W, 10, width of the feature-buffer word address; max in_words = 2^ADDR_W.
- CNT_W, 16, width of the row and word counters.
- MAC_LAT, 2, cycles from the last mac_en to a valid acc_in (allowed range 1..15).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  one-cycle command pulse from the APB block.
- in_words  in  CNT_W  32-bit words per feature vector and per weight row (4 int8 per word). Sampled on start.
- out_len  in  CNT_W  number of output neurons (rows). Sampled on start.
- s_valid  in  1  input stream valid.
- s_last  in  1  input stream TLAST.
- s_ready  out  1  input stream ready.
- feat_we  out  1  feature-buffer write enable.
- feat_addr  out  ADDR_W  feature-buffer write address.
- mac_en  out  1  MAC consumes the current stream word.
- mac_addr  out  ADDR_W  feature-buffer read address paired with mac_en.
- acc_clr  out  1  clear accumulator; asserted together with mac_en on the first beat of a row.
- acc_in  in  32  signed accumulator value from the datapath.
- m_valid  out  1  output stream valid.
- m_ready  in  1  output stream ready.
- m_data  out  32  result word.
- m_last  out  1  asserted on the last row's result.
- max_index  out  CNT_W  row index of the largest result.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse at end of layer.
- err  out  1  sticky error flag; cleared by the next accepted start.

Behaviour:
- Reset state: FSM=IDLE; all outputs 0; counters 0; max_index 0; err 0.
- States: IDLE, LOAD, ROW, DRAIN, EMIT, DONE.
- IDLE:
  - start latches in_words/out_len, clears err and the counters, and goes to LOAD.
  - start is ignored in all other states.
  - If the latched in_words==0 or out_len==0, go to DONE with err=1.
- LOAD:
  - s_ready=1.
  - Each handshake (s_valid&s_ready) drives feat_we=1 and feat_addr=word_cnt combinationally in the same cycle, then increments word_cnt.
  - On beat in_words-1: word_cnt is cleared and the FSM goes to ROW.
  - s_last on any LOAD beat is ignored.
- ROW:
  - s_ready=1.
  - Each handshake drives mac_en=1 and mac_addr=word_cnt in the same cycle; acc_clr=1 when word_cnt==0.
  - On beat in_words-1: go to DRAIN and load the latency counter with MAC_LAT.
  - s_last asserted on the final beat of the final row is the expected case.
  - s_last on any other ROW beat sets err=1 and goes to DONE (abort). No result is emitted for the current row.
- DRAIN:
  - s_ready=0.
  - Count down MAC_LAT cycles. At zero, register acc_in into m_data and go to EMIT.
- EMIT:
  - m_valid=1; m_data is held stable until m_ready.
  - m_last = (row_cnt==out_len-1).
  - Arg-max is updated in the cycle the result enters EMIT:
    - row 0 loads max_val/max_index unconditionally;
    - later rows update only if acc_in > max_val (signed);
    - ties keep the lower index.
  - On m_valid&m_ready: if it was the last row, go to DONE; else increment row_cnt, clear word_cnt and go to ROW.
- DONE:
  - done=1 for exactly one cycle, then IDLE.
  - max_index and err hold until the next start.
- The output is never back-pressured into the input: s_ready=0 in DRAIN/EMIT/DONE/IDLE.
- Async rst at any time returns to the reset state immediately. Partial results are discarded and done is not pulsed.
- Counters wrap only via the explicit clears above. in_words > 2^ADDR_W is a caller error; addresses truncate to ADDR_W bits.

Test Plan:
- Basic layer:
  - Stimulus: start with in_words=4, out_len=3; 4 feature beats, then 3×4 weight beats; datapath model returns acc 10, -5, 7.
  - Response: 4 feat_we with addr 0..3; 12 mac_en with acc_clr on beats 0,4,8; m_data 10,-5,7; m_last on the third result; max_index=0; one done pulse; err=0.
- Back-pressure:
  - Stimulus: same layer, with m_ready held low for 5 cycles on each result.
  - Response: m_data stable while waiting; s_ready=0 during EMIT; results and count unchanged.
- Arg-max ties and negatives:
  - Stimulus: results -8, -3, -3, -9.
  - Response: max_index=1.
- Early TLAST:
  - Stimulus: in_words=4, out_len=2; s_last asserted on the 2nd beat of row 0.
  - Response: err=1; no m_valid; done pulse; FSM back in IDLE; next start clears err.
- Zero length and ignored start:
  - Stimulus: start with out_len=0.
  - Response: done within 2 cycles, err=1, no s_ready.
  - Also: a start pulse issued mid-LOAD has no effect.
- Reset mid-run:
  - Stimulus: assert rst during ROW of row 1.
  - Response: all outputs 0 in the same cycle, no done pulse; a subsequent full layer completes correctly.
